// File: rtl/tqvp_raster_scheduler.sv
// Beam-position event sequencer: walks a CPU-programmed table of (x, y) events each
// frame, switching the output colour and optionally raising an interrupt as the beam passes.
module tqvp_raster_scheduler #(
    parameter int NUM_EVENTS = 8,
    parameter int PTR_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    output logic [5:0]  rgb,
    output logic        user_interrupt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ARMED = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [7:0]       r_ctrl;
    logic [31:0]      r_entry [NUM_EVENTS];
    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [5:0]       r_color;
    logic             r_irq_pending;
    logic [5:0]       r_rgb;
    logic             r_at_origin_d;

    logic        w_write;
    logic        w_word;
    logic        w_ctrl_wr;
    logic        w_status_clr;
    logic        w_run;
    logic        w_frame_start;
    logic [31:0] w_cur;
    logic        w_match;
    logic        w_unused;

    assign w_write      = (data_write_n != 2'b11);
    assign w_word       = (data_write_n == 2'b10);
    assign w_ctrl_wr    = w_write && (address == 6'h00);
    assign w_status_clr = w_write && (address == 6'h04) && data_in[0];
    // A run=0 write lands in IDLE on its own edge, so it beats a coincident frame_start.
    assign w_run        = w_ctrl_wr ? data_in[0] : r_ctrl[0];

    assign w_frame_start = (hpos == '0) && (vpos == '0) && !r_at_origin_d;
    assign w_cur         = r_entry[r_ptr];
    // {y, x} sits in the low 20 bits of an entry, so one unsigned compare orders beam position.
    assign w_match       = ({vpos, hpos} >= w_cur[19:0]);

    assign w_unused = &{1'b0, data_read_n};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= data_in[7:0];
            end
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (w_word && (address == 6'(32 + 4 * i))) begin
                    r_entry[i] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_color       <= '0;
            r_irq_pending <= 1'b0;
            r_rgb         <= '0;
            r_at_origin_d <= 1'b0;
        end else begin
            r_at_origin_d <= (hpos == '0) && (vpos == '0);
            // Clear first so that an irq-setting event on the same edge overrides it.
            if (w_status_clr) begin
                r_irq_pending <= 1'b0;
            end
            if (!w_run) begin
                r_state <= S_IDLE;
                r_ptr   <= '0;
            end else if (r_state == S_IDLE) begin
                r_state <= S_WAIT;
            end else if (w_frame_start) begin
                r_color <= r_ctrl[6:1];
                r_ptr   <= '0;
                r_state <= S_ARMED;
            end else if (r_state == S_ARMED) begin
                if (!w_cur[31]) begin
                    r_state <= S_DONE;
                end else if (w_match) begin
                    r_color <= w_cur[25:20];
                    if (w_cur[30]) begin
                        r_irq_pending <= 1'b1;
                    end
                    if (r_ptr == PTR_W'(NUM_EVENTS - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
            end
            r_rgb <= (r_ctrl[0] && display_on) ? r_color : '0;
        end
    end

    always_comb begin
        data_out = '0;
        if (address == 6'h00) begin
            data_out[7:0] = r_ctrl;
        end else if (address == 6'h04) begin
            data_out[PTR_W+2:3] = r_ptr;
            data_out[2:1]       = r_state;
            data_out[0]         = r_irq_pending;
        end
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (address == 6'(32 + 4 * i)) begin
                data_out = r_entry[i];
            end
        end
    end

    assign data_ready     = 1'b1;
    assign rgb            = r_rgb;
    assign user_interrupt = r_irq_pending & r_ctrl[7];

endmodule

// File: tb/tb_tqvp_raster_scheduler.sv
// Bench for tqvp_raster_scheduler: register vectors, frame sweeps against a fire-time
// model of the event list, and hand-stepped corner sequences.
module tb_tqvp_raster_scheduler;

    localparam int H     = 128;
    localparam int V     = 6;
    localparam int DE_W  = 112;
    localparam int FRAME = H * V;

    logic        clk;
    logic        rst_n;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_on;
    logic [5:0]  rgb;
    logic        user_interrupt;

    tqvp_raster_scheduler #(.NUM_EVENTS(8), .PTR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
        .data_ready(data_ready), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .rgb(rgb), .user_interrupt(user_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  wn;
        logic [5:0]  raddr;
        logic [31:0] exp;
    } bus_vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] tb_entry [8];
    logic [7:0]  tb_ctrl;
    logic [5:0]  m_color;
    logic        m_irq;
    logic [31:0] rd;
    bus_vec_t    vec [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_entry(input int x, input int y, input int c,
                                             input bit irq, input bit valid);
        return {valid, irq, 4'd0, 6'(c), 10'(y), 10'(x)};
    endfunction

    task automatic set_beam(input int t);
        hpos       = 10'(t % H);
        vpos       = 10'(t / H);
        display_on = (t % H) < DE_W;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        @(posedge clk);
        #1;
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    // Stops the scheduler, loads tb_entry[] and then starts it with the given CTRL value.
    task automatic setup(input logic [7:0] ctrl, input logic [1:0] ctrl_wn);
        bus_write(6'h00, 32'h0, 2'b10);
        bus_write(6'h04, 32'h1, 2'b10);
        m_irq = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus_write(6'(32 + 4 * k), tb_entry[k], 2'b10);
        end
        bus_write(6'h00, {$urandom, ctrl} >> 0 & 32'hFFFF_FF00 | {24'd0, ctrl}, ctrl_wn);
        tb_ctrl = ctrl;
    endtask

    // Event k fires at beam index max(pos_k, fire_{k-1}+1); the frame_start edge (index 0)
    // never fires, and the list stops at the first entry without its valid bit.
    task automatic run_frame(input int n_cyc, input int clr_t);
        int  fire_t [8];
        int  n_fire;
        int  prev;
        int  p;
        logic [5:0] exp_rgb;
        n_fire = 0;
        prev   = 0;
        for (int k = 0; k < 8; k++) begin
            if (!tb_entry[k][31]) break;
            p = int'(tb_entry[k][19:10]) * H + int'(tb_entry[k][9:0]);
            fire_t[k] = (p > prev + 1) ? p : prev + 1;
            prev      = fire_t[k];
            n_fire    = k + 1;
        end
        for (int t = 0; t < n_cyc; t++) begin
            set_beam(t);
            if (t == clr_t) begin
                address      = 6'h04;
                data_in      = 32'h1;
                data_write_n = 2'b00;
            end
            @(posedge clk);
            #1;
            data_write_n = 2'b11;
            exp_rgb = (tb_ctrl[0] && display_on) ? m_color : 6'd0;
            if (t == 0) m_color = tb_ctrl[6:1];
            if (t == clr_t) m_irq = 1'b0;
            for (int k = 0; k < n_fire; k++) begin
                if (fire_t[k] == t) begin
                    m_color = tb_entry[k][25:20];
                    if (tb_entry[k][30]) m_irq = 1'b1;
                end
            end
            chk($sformatf("rgb@%0d", t), {26'd0, rgb}, {26'd0, exp_rgb});
            chk($sformatf("irq@%0d", t), {31'd0, user_interrupt}, {31'd0, m_irq & tb_ctrl[7]});
        end
    endtask

    initial begin
        int pos [8];
        int n_valid;
        int tmp;

        vec[0]  = '{6'h00, 32'hFFFF_FF8A, 2'b10, 6'h00, 32'h0000_008A};
        vec[1]  = '{6'h00, 32'h0000_0016, 2'b00, 6'h00, 32'h0000_0016};
        vec[2]  = '{6'h00, 32'h0000_A534, 2'b01, 6'h00, 32'h0000_0034};
        vec[3]  = '{6'h20, 32'h8012_3456, 2'b10, 6'h20, 32'h8012_3456};
        vec[4]  = '{6'h24, 32'hFFFF_FFFF, 2'b00, 6'h24, 32'h0000_0000};
        vec[5]  = '{6'h24, 32'hFFFF_FFFF, 2'b01, 6'h24, 32'h0000_0000};
        vec[6]  = '{6'h3C, 32'hC000_0001, 2'b10, 6'h3C, 32'hC000_0001};
        vec[7]  = '{6'h10, 32'hFFFF_FFFF, 2'b10, 6'h10, 32'h0000_0000};
        vec[8]  = '{6'h00, 32'h0,         2'b11, 6'h04, 32'h0000_0000};
        vec[9]  = '{6'h04, 32'h0000_0001, 2'b10, 6'h04, 32'h0000_0000};
        vec[10] = '{6'h00, 32'h0,         2'b11, 6'h1C, 32'h0000_0000};
        vec[11] = '{6'h20, 32'h0,         2'b10, 6'h20, 32'h0000_0000};
        vec[12] = '{6'h3C, 32'h0,         2'b10, 6'h3C, 32'h0000_0000};
        vec[13] = '{6'h00, 32'h0,         2'b10, 6'h00, 32'h0000_0000};

        // clock/reset
        rst_n = 1'b0; address = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
        set_beam(FRAME - 1);
        tb_ctrl = 8'h00; m_color = 6'd0; m_irq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        bus_read(6'h00, rd); chk("rst_ctrl", rd, 32'h0);
        bus_read(6'h04, rd); chk("rst_status", rd, 32'h0);
        bus_read(6'h20, rd); chk("rst_entry0", rd, 32'h0);
        chk("rst_rgb", {26'd0, rgb}, 32'h0);
        chk("rst_irq", {31'd0, user_interrupt}, 32'h0);
        chk("data_ready", {31'd0, data_ready}, 32'h1);

        for (int i = 0; i < 14; i++) begin
            if (vec[i].wn != 2'b11) bus_write(vec[i].waddr, vec[i].wdata, vec[i].wn);
            bus_read(vec[i].raddr, rd);
            chk($sformatf("vec%0d", i), rd, vec[i].exp);
        end

        // Basic frame: one irq event at (100,2).
        for (int k = 0; k < 8; k++) tb_entry[k] = 32'h0;
        tb_entry[0] = mk_entry(100, 2, 6'h3F, 1'b1, 1'b1);
        setup(8'h8B, 2'b10);
        run_frame(FRAME, -1);
        bus_read(6'h04, rd); chk("basic_status", rd, 32'h0000_000F);

        // Catch-up: three entries at (0,5).
        for (int k = 0; k < 8; k++) tb_entry[k] = 32'h0;
        for (int k = 0; k < 3; k++) tb_entry[k] = mk_entry(0, 5, k + 1, 1'b0, 1'b1);
        setup(8'h8B, 2'b10);
        run_frame(FRAME, -1);
        bus_read(6'h04, rd); chk("catchup_status", rd, 32'h0000_001E);

        // All eight valid: ptr holds at 7 and the second frame replays identically.
        for (int k = 0; k < 8; k++) tb_entry[k] = mk_entry(10 + 10 * k, 1, 8 + k, k == 7, 1'b1);
        setup(8'h8B, 2'b10);
        run_frame(FRAME, -1);
        bus_read(6'h04, rd); chk("full_status", rd, 32'h0000_003F);
        run_frame(FRAME, -1);
        bus_read(6'h04, rd); chk("full_status2", rd, 32'h0000_003F);

        // Status clear on the same edge the irq entry fires (index 1*H+20).
        for (int k = 0; k < 8; k++) tb_entry[k] = 32'h0;
        tb_entry[0] = mk_entry(20, 1, 6'h11, 1'b1, 1'b1);
        setup(8'h8B, 2'b10);
        run_frame(FRAME, H + 20);
        bus_read(6'h04, rd); chk("clr_vs_set_status", rd, 32'h0000_000F);

        // Clear run mid-line, then re-enable: waits for the next frame_start.
        for (int k = 0; k < 8; k++) tb_entry[k] = 32'h0;
        tb_entry[0] = mk_entry(100, 2, 6'h3F, 1'b1, 1'b1);
        tb_entry[1] = mk_entry(50, 4, 6'h2A, 1'b0, 1'b1);
        setup(8'h8B, 2'b10);
        run_frame(2 * H + 10, -1);
        set_beam(2 * H + 10);
        bus_write(6'h00, 32'h8A, 2'b10);
        tb_ctrl = 8'h8A;
        bus_read(6'h04, rd); chk("runclr_idle", rd, 32'h0);
        set_beam(2 * H + 11);
        @(posedge clk);
        #1;
        chk("runclr_rgb", {26'd0, rgb}, 32'h0);
        set_beam(2 * H + 12);
        bus_write(6'h00, 32'h8B, 2'b10);
        tb_ctrl = 8'h8B;
        bus_read(6'h04, rd); chk("rerun_wait", rd, 32'h0000_0002);
        for (int t = 2 * H + 13; t < FRAME; t++) begin
            set_beam(t);
            @(posedge clk);
            #1;
            chk($sformatf("wait_rgb@%0d", t), {26'd0, rgb}, display_on ? {26'd0, m_color} : 32'h0);
        end
        chk("wait_irq", {31'd0, user_interrupt}, 32'h0);
        bus_read(6'h04, rd); chk("wait_status", rd, 32'h0000_0002);
        run_frame(FRAME, -1);
        bus_read(6'h04, rd); chk("rerun_status", rd, 32'h0000_0017);

        // Randomized tables in ascending beam order, with an invalid terminator and ignored
        // narrow entry writes; each table is swept for two frames.
        for (int s = 0; s < 6; s++) begin
            n_valid = $urandom_range(0, 8);
            for (int k = 0; k < 8; k++) pos[k] = $urandom_range(0, (V - 1) * H - 1);
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 7 - i; j++)
                    if (pos[j] > pos[j + 1]) begin
                        tmp = pos[j]; pos[j] = pos[j + 1]; pos[j + 1] = tmp;
                    end
            for (int k = 0; k < 8; k++) begin
                tb_entry[k] = mk_entry(pos[k] % H, pos[k] / H, $urandom_range(0, 63),
                                       1'($urandom_range(0, 1)), k != n_valid);
            end
            setup({1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b1},
                  2'($urandom_range(0, 2)));
            bus_write(6'(32 + 4 * $urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 1)));
            run_frame(FRAME, -1);
            run_frame(FRAME, $urandom_range(0, FRAME - 1));
        end

        // Reset asserted mid-frame.
        for (int k = 0; k < 8; k++) tb_entry[k] = 32'h0;
        tb_entry[0] = mk_entry(20, 1, 6'h2D, 1'b1, 1'b1);
        setup(8'h8B, 2'b10);
        run_frame(300, -1);
        set_beam(300);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_rgb", {26'd0, rgb}, 32'h0);
        chk("midrst_irq", {31'd0, user_interrupt}, 32'h0);
        bus_read(6'h00, rd); chk("midrst_ctrl", rd, 32'h0);
        bus_read(6'h04, rd); chk("midrst_status", rd, 32'h0);
        bus_read(6'h20, rd); chk("midrst_entry0", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tqvp_raster_scheduler.md
# tqvp_raster_scheduler

Beam-position event sequencer for the TinyQV video peripheral. It watches the horizontal/vertical position and display-enable from the VGA timing generator. It walks a CPU-programmed list of up to NUM_EVENTS entries, changing the output colour and optionally raising an interrupt when the beam reaches each entry's (x, y). It sits between the timing generator and the pixel output pins and is configured over the TinyQV peripheral bus.

## Interface
Parameters:
- NUM_EVENTS, 8: event table depth (power of two, 2..16).
- PTR_W, 3: log2(NUM_EVENTS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- address  in  6  bus register address.
- data_in  in  32  bus write data.
- data_write_n  in  2  11 none, 00 byte, 01 half, 10 word.
- data_read_n  in  2  read strobe; unused, reads have no side effects.
- data_out  out  32  read data, combinational from address.
- data_ready  out  1  constant 1.
- hpos  in  10  current pixel column from the timing generator.
- vpos  in  10  current line from the timing generator.
- display_on  in  1  active-video flag from the timing generator.
- rgb  out  6  {R[1:0], G[1:0], B[1:0]}, registered.
- user_interrupt  out  1  level, equals irq_pending & ctrl.irq_en.

## Operation
- Register map:
  - 0x00 CTRL (rw): bit0 run, bits[6:1] bg colour, bit7 irq_en. Byte writes update [7:0] only; all wider writes update [7:0].
  - 0x04 STATUS (read {ptr, state[1:0], irq_pending}; bits [PTR_W+2:3]=ptr, [2:1]=state, [0]=irq_pending): writing any width with data_in[0]=1 clears irq_pending.
  - 0x20+4*i ENTRY[i] (rw, word writes only; other widths ignored): [9:0] x, [19:10] y, [25:20] colour, [30] irq, [31] valid.
  - Unmapped addresses read 0.
- frame_start is a one-cycle pulse: (hpos==0 && vpos==0) this cycle and not in the previous cycle.
- State machine, with encodings IDLE=0, WAIT=1, ARMED=2, DONE=3:
  - IDLE: entered when run=0. color_reg is held. ptr=0. From IDLE, run=1 moves to WAIT.
  - WAIT, ARMED and DONE: frame_start loads color_reg<=bg, sets ptr<=0 and moves to ARMED. This applies in any state except IDLE.
  - ARMED: cur=ENTRY[ptr].
    - If cur.valid=0, move to DONE.
    - Otherwise, a match occurs when {vpos,hpos} >= {cur.y,cur.x} as an unsigned 20-bit compare.
    - On a match: color_reg<=cur.colour, irq_pending<=1 if cur.irq, and ptr advances.
    - If ptr was NUM_EVENTS-1, move to DONE instead of wrapping.
  - DONE: waits for frame_start.
- At most one event fires per clock. Entries whose positions have already passed fire on consecutive cycles in table order. Software must program entries in ascending beam order.
- Clearing run in any state moves to IDLE on the next edge, and rgb is forced to 0.
- Table writes mid-frame take effect at the next compare. Rewriting the current entry is allowed.

## Timing
- Reset values: CTRL=0, all ENTRY=0, state=IDLE, ptr=0, color_reg=0, irq_pending=0, rgb=0, user_interrupt=0.
- Match evaluated on edge N updates color_reg at N. At edge N+1, rgb <= (run && display_on) ? color_reg : 0. This gives 2 cycles from hpos/vpos presentation to the rgb change.
- user_interrupt is asserted the cycle after the firing edge, via the registered irq_pending.
- Simultaneous events:
  - frame_start and a match in the same cycle: frame_start wins and no event fires.
  - Status clear and a new irq-set in the same cycle: set wins.
  - A run=0 write and frame_start in the same cycle: IDLE wins.
- Reset asserted mid-frame: all state returns to reset values on that edge.

## Test plan
- Reset, then read 0x00/0x04/0x20: all return 0; rgb=0; user_interrupt=0.
- Setup: CTRL=0x8B (run, bg=0x05, irq_en); ENTRY0 = x=100, y=2, colour=0x3F, irq, valid; ENTRY1 = 0. Sweep a frame.
  - After frame_start, rgb=0x05 while display_on.
  - rgb=0x3F from 2 cycles after (100,2).
  - user_interrupt rises 1 cycle after the match.
  - STATUS.state=DONE.
- Catch-up: ENTRY0..2 all at (0,5) with colours 1, 2, 3. At (0,5), color_reg steps 1→2→3 on three consecutive cycles and ptr=3.
- All 8 entries valid: after the eighth fires, state=DONE, ptr does not wrap, and no further colour change occurs until the next frame_start.
- Write STATUS=1 in the same cycle as an irq entry fires: irq_pending stays 1.
- Clear run mid-line: rgb=0 the next cycle and state=IDLE. Set run again: waits in WAIT until frame_start and does not fire mid-frame.
